program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter len_addr, default 11, program-memory address width.
REQ-002 The block SHALL have parameter len_data, default 16, instruction word width; fixed at 2 bytes.
REQ-003 The block SHALL have parameter ram_depth, default 2048, program-memory word count.
REQ-004 Port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse that begins or restarts a load.
REQ-007 Port rx_data, input, 8 bits: byte from the UART receiver.
REQ-008 Port rx_done, input, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-009 Port Wr, output, 1 bit: write strobe to the program-memory write port.
REQ-010 Port Addr, output, len_addr bits: write address.
REQ-011 Port Data, output, len_data bits: write data.
REQ-012 Port cpu_reset, output, 1 bit: holds the CPU in reset while high.
REQ-013 Port done, output, 1 bit: load complete.
REQ-014 Port word_count, output, len_addr+1 bits: words written in the current load, terminator included.
REQ-015 Port overrun, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, LOW, HIGH, WRITE, DONE.
REQ-017 IDLE: the block SHALL wait for start; start moves it to LOW, with Addr=0 and word_count=0.
REQ-018 LOW: on rx_done, the block SHALL latch rx_data into Data[7:0] and move to HIGH.
REQ-019 HIGH: on rx_done, the block SHALL latch rx_data into Data[15:8] and move to WRITE.
REQ-020 WRITE SHALL last exactly one cycle.
  - Wr=1, with Addr and Data stable.
  - word_count increments by 1.
REQ-021 Write latency: Wr SHALL be high in the cycle immediately after the cycle in which the high-byte rx_done is sampled.
REQ-022 Leaving WRITE, the block SHALL go to DONE if Data==16'h0000 (HALT, opcode 00000, operand 0) or if Addr==ram_depth-1.
REQ-023 Leaving WRITE otherwise, the block SHALL increment Addr by 1 and go to LOW.
  - Addr never wraps past ram_depth-1.
REQ-024 DONE: the block SHALL drive done=1 and cpu_reset=0, and hold Addr, Data and word_count.
REQ-025 cpu_reset SHALL be 1 in every state except DONE.
REQ-026 done SHALL be 1 only in DONE.
REQ-027 Wr SHALL be 1 only in WRITE.
REQ-028 rx_done while in WRITE, IDLE or DONE: the byte SHALL be discarded; in WRITE it also sets overrun.
REQ-029 start in any state SHALL take priority over rx_done.
  - Abort the current load; next state is LOW with Addr=0 and word_count=0.
  - overrun is cleared.
  - A start in DONE re-asserts cpu_reset from the next cycle.
REQ-030 start and rx_done in the same cycle: the block SHALL act on start only; the byte is discarded.
REQ-031 A start pulse during a load SHALL discard any partially received word; no write is issued for it.

Reset
REQ-032 On reset=1, at the next rising edge the block SHALL set:
  - state=IDLE
  - Wr=0, Addr=0, Data=0
  - cpu_reset=1, done=0
  - word_count=0, overrun=0
REQ-033 reset SHALL take priority over start and rx_done.
REQ-034 reset mid-load SHALL abandon the load with no further Wr pulse.

Structure
REQ-035 The following SHALL be defined once in the shared header used by TOP, CPU and the memories:
  - len_addr, len_data, ram_depth
  - HALT word value 16'h0000
  - FSM state encodings
REQ-036 No sub-module SHALL be used; the byte assembly and the FSM are one sequential block.
REQ-037 The program memory gains a synchronous write port (Wr, Addr, Data) driven only by this block.
REQ-038 TOP SHALL combine cpu_reset with the system reset (OR) before driving the CPU reset.

Verification
REQ-039 Scenario: reset, start, then bytes 0x05,0x18, 0x00,0x00 -> Wr at Addr 0 with Data 0x1805, then Wr at Addr 1 with Data 0x0000; then done=1, cpu_reset=0, word_count=2.
REQ-040 Scenario: rx_done in the same cycle as start -> the byte is ignored; the next two bytes form word 0 at Addr 0.
REQ-041 Scenario: rx_done held for the single WRITE cycle -> overrun=1, no extra write, Addr advances normally.
REQ-042 Scenario: stream 2048 nonzero words -> the last Wr is at Addr 0x7FF; DONE is entered with word_count=2048 and no wrap to 0.
REQ-043 Scenario: start after one byte of word 3 -> no write at Addr 3; loading resumes at Addr 0; overrun=0.
REQ-044 Scenario: reset asserted in HIGH -> next cycle state=IDLE, cpu_reset=1, done=0, and no Wr pulse.

Source files
------------

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader, the CPU and the program memory:
// memory geometry, the HALT instruction word and the loader FSM encoding.
// ---------------------------------------------------------------------------
package program_loader_pkg;

  // Program-memory geometry. The instruction word is fixed at two bytes.
  localparam int PL_LEN_ADDR  = 11;
  localparam int PL_LEN_DATA  = 16;
  localparam int PL_RAM_DEPTH = 2048;

  // HALT: opcode 00000, operand 0. Writing it terminates a load.
  localparam logic [15:0] HALT_WORD = 16'h0000;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Assembles little-endian byte pairs from a UART receiver into instruction
// words and writes them to consecutive program-memory addresses from 0. The
// load ends after a HALT word or after the last memory location is written;
// the CPU is held in reset until then.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse: begin or restart a load (beats rx_done)
//   rx_data     received byte, valid when rx_done is high
//   rx_done     one-cycle receive strobe
//   Wr          program-memory write strobe (high only in WRITE)
//   Addr        program-memory write address
//   Data        program-memory write data
//   cpu_reset   high in every state except DONE
//   done        high only in DONE
//   word_count  words written in this load, terminator included
//   overrun     sticky: a byte arrived during WRITE and was dropped
// ---------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int len_addr  = PL_LEN_ADDR,
  parameter int len_data  = PL_LEN_DATA,
  parameter int ram_depth = PL_RAM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic                Wr,
  output logic [len_addr-1:0] Addr,
  output logic [len_data-1:0] Data,
  output logic                cpu_reset,
  output logic                done,
  output logic [len_addr:0]   word_count,
  output logic                overrun
);

  localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);
  localparam logic [len_addr-1:0] ADDR_ONE  = len_addr'(1);
  localparam logic [len_addr:0]   COUNT_ONE = (len_addr + 1)'(1);

  state_t state;
  state_t state_next;

  // A write is the last one when it carries HALT or fills the top location;
  // this is also what keeps Addr from ever wrapping back to 0.
  logic last_word;
  assign last_word = (Data == len_data'(HALT_WORD)) || (Addr == LAST_ADDR);

  // Next-state logic. start overrides everything, including a byte that
  // arrives in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    if (start) begin
      state_next = ST_LOW;
    end else begin
      unique case (state)
        ST_IDLE:  state_next = ST_IDLE;
        ST_LOW:   if (rx_done) state_next = ST_HIGH;
        ST_HIGH:  if (rx_done) state_next = ST_WRITE;
        ST_WRITE: state_next = last_word ? ST_DONE : ST_LOW;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State register together with byte assembly, addressing and counters.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // values from before this edge, independent of statement order.
    if (reset) begin
      state      <= ST_IDLE;
      Addr       <= '0;
      Data       <= '0;
      word_count <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        // Abort: any half-assembled word is simply overwritten later.
        Addr       <= '0;
        word_count <= '0;
        overrun    <= 1'b0;
      end else begin
        unique case (state)
          ST_LOW:   if (rx_done) Data[7:0] <= rx_data;
          ST_HIGH:  if (rx_done) Data[len_data-1:8] <= rx_data;
          ST_WRITE: begin
            word_count <= word_count + COUNT_ONE;
            if (rx_done) overrun <= 1'b1;
            if (!last_word) Addr <= Addr + ADDR_ONE;
          end
          default: ;  // IDLE and DONE discard bytes and hold everything
        endcase
      end
    end
  end

  assign Wr        = (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign cpu_reset = (state != ST_DONE);

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. Every write the bench causes is
// queued as {addr, data}; a negedge monitor pops and compares each Wr pulse,
// and flags any Wr that nothing asked for.
// ---------------------------------------------------------------------------
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int LA    = PL_LEN_ADDR;
  localparam int LD    = PL_LEN_DATA;
  localparam int DEPTH = PL_RAM_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          wr;
  logic [LA-1:0] addr;
  logic [LD-1:0] data;
  logic          cpu_reset;
  logic          done;
  logic [LA:0]   word_count;
  logic          overrun;

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .Wr         (wr),
    .Addr       (addr),
    .Data       (data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .word_count (word_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [LA-1:0] addr;
    logic [LD-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_item;
  int  exp_addr = 0;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         wr_addr;
    int         count_after;
    logic       done_after;
    int         addr_after;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: each Wr pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(exp_item.addr));
        check("wr_data", 32'(data), 32'(exp_item.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    exp_q.push_back('{addr: LA'(exp_addr), data: w});
    exp_addr++;
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;

    vecs[0] = '{8'h05, 8'h18, 0, 1, 1'b0, 1};
    vecs[1] = '{8'hF0, 8'hA5, 1, 2, 1'b0, 2};
    vecs[2] = '{8'hFF, 8'hFF, 2, 3, 1'b0, 3};
    vecs[3] = '{8'h01, 8'h00, 3, 4, 1'b0, 4};
    vecs[4] = '{8'h00, 8'h01, 4, 5, 1'b0, 5};
    vecs[5] = '{8'h00, 8'h00, 5, 6, 1'b1, 5};

    // Reset state.
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // A byte in IDLE is discarded.
    send_byte(8'h55);
    @(negedge clk);
    check("idle_discard_data", 32'(data), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Table-driven load ending with HALT.
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check("vec_wr_addr_model", 32'(exp_addr), 32'(vecs[i].wr_addr));
      exp_q.push_back('{addr: LA'(vecs[i].wr_addr), data: {vecs[i].hi, vecs[i].lo}});
      exp_addr++;
      send_byte(vecs[i].lo);
      send_byte(vecs[i].hi);
      @(negedge clk);
      check("vec_wr_strobe", 32'(wr), 32'd1);
      @(negedge clk);
      check("vec_word_count", 32'(word_count), 32'(vecs[i].count_after));
      check("vec_done", 32'(done), 32'(vecs[i].done_after));
      check("vec_addr", 32'(addr), 32'(vecs[i].addr_after));
    end
    check("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    check("halt_data", 32'(data), 32'h0000);

    // A byte in DONE is discarded and everything holds.
    send_byte(8'h77);
    @(negedge clk);
    check("done_hold_data", 32'(data), 32'h0000);
    check("done_hold_count", 32'(word_count), 32'd6);
    check("done_hold_done", 32'(done), 32'd1);

    // start and rx_done together: the byte is ignored; start from DONE
    // re-asserts cpu_reset.
    @(posedge clk); #1;
    start   = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hEE;
    @(posedge clk); #1;
    start   = 1'b0;
    rx_done = 1'b0;
    exp_addr = 0;
    @(negedge clk);
    check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_count", 32'(word_count), 32'd0);
    send_word(16'h1234);

    // rx_done held through the WRITE cycle: overrun, no extra write.
    exp_q.push_back('{addr: LA'(exp_addr), data: 16'h3322});
    exp_addr++;
    send_byte(8'h22);
    @(posedge clk); #1;
    rx_data = 8'h33;
    rx_done = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_addr", 32'(addr), 32'd2);
    check("ovr_count", 32'(word_count), 32'd2);
    send_word(16'h4455);

    // start after the low byte of word 3: no write for it, overrun clears.
    send_byte(8'h99);
    pulse_start();
    @(negedge clk);
    check("abort_overrun", 32'(overrun), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_count", 32'(word_count), 32'd0);
    send_word(16'hBEEF);
    send_word(16'h0000);
    tick(2);
    @(negedge clk);
    check("abort_done", 32'(done), 32'd1);
    check("abort_final_count", 32'(word_count), 32'd2);
    check("abort_final_addr", 32'(addr), 32'd1);

    // reset while in HIGH: back to IDLE, no write.
    pulse_start();
    send_byte(8'h11);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rsthigh_wr", 32'(wr), 32'd0);
    check("rsthigh_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rsthigh_done", 32'(done), 32'd0);
    check("rsthigh_addr", 32'(addr), 32'd0);
    check("rsthigh_count", 32'(word_count), 32'd0);
    send_byte(8'h22);
    tick(3);
    @(negedge clk);
    check("rsthigh_idle_data", 32'(data), 32'd0);

    // Fill the whole memory with nonzero words: stop at the top, no wrap.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send_word(16'(i + 1));
    begin
      int budget = 10;
      @(negedge clk);
      while (done !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    check("full_done", 32'(done), 32'd1);
    check("full_count", 32'(word_count), 32'(DEPTH));
    check("full_addr", 32'(addr), 32'(DEPTH - 1));
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    tick(2);
    @(negedge clk);
    check("full_hold_addr", 32'(addr), 32'(DEPTH - 1));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // start from DONE: CPU back in reset from the next cycle.
    pulse_start();
    @(negedge clk);
    check("final_cpu_reset", 32'(cpu_reset), 32'd1);
    check("final_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
